// File: rtl/div_pipe_sgn.sv
// div_pipe_sgn: pipelined signed/unsigned restoring divider with stall, bubbles and divide-by-zero flag
module div_pipe_sgn #(
    parameter int DATA_W          = 32,
    parameter int OPERS_PER_STAGE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              valid_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              valid_o,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              dbz_o
);
    localparam int N = DATA_W / OPERS_PER_STAGE;
    localparam logic [DATA_W-1:0] smin = {1'b1, {(DATA_W-1){1'b0}}};

    if (DATA_W < 2 || DATA_W % OPERS_PER_STAGE != 0) begin : g_chk
        $error("div_pipe_sgn: DATA_W must be >= 2 and a multiple of OPERS_PER_STAGE");
    end

    logic [N:0] v, sq, sr, dbz, ovf;
    logic [DATA_W-1:0] rem [0:N];
    logic [DATA_W-1:0] qd  [0:N];
    logic [DATA_W-1:0] dvs [0:N];
    logic [DATA_W-1:0] r_n [0:N-1];
    logic [DATA_W-1:0] q_n [0:N-1];
    logic [DATA_W-1:0] r_c, q_c, ad, av;
    logic [DATA_W:0] t;
    logic sd, sv, z, o;

    always_comb begin
        sd = signed_i & dividend[DATA_W-1];
        sv = signed_i & divisor[DATA_W-1];
        ad = sd ? -dividend : dividend;
        av = sv ? -divisor : divisor;
        z  = divisor == '0;
        o  = signed_i && dividend == smin && divisor == '1;
    end

    // qd shifts dividend bits out the top and quotient bits in the bottom
    always_comb begin
        r_n = '{default: '0};
        q_n = '{default: '0};
        r_c = '0;
        q_c = '0;
        t   = '0;
        for (int s = 0; s < N; s++) begin
            r_c = rem[s];
            q_c = qd[s];
            for (int k = 0; k < OPERS_PER_STAGE; k++) begin
                t   = {r_c, q_c[DATA_W-1]};
                q_c = {q_c[DATA_W-2:0], t >= {1'b0, dvs[s]}};
                r_c = t >= {1'b0, dvs[s]} ? DATA_W'(t - {1'b0, dvs[s]}) : t[DATA_W-1:0];
            end
            r_n[s] = r_c;
            q_n[s] = q_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v         <= '0;
            sq        <= '0;
            sr        <= '0;
            dbz       <= '0;
            ovf       <= '0;
            rem       <= '{default: '0};
            qd        <= '{default: '0};
            dvs       <= '{default: '0};
            valid_o   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz_o     <= 1'b0;
        end else if (en) begin
            v      <= {v[N-1:0], valid_i};
            sq     <= {sq[N-1:0], sd ^ sv};
            sr     <= {sr[N-1:0], sd};
            dbz    <= {dbz[N-1:0], z};
            ovf    <= {ovf[N-1:0], o};
            rem[0] <= '0;
            qd[0]  <= ad;
            dvs[0] <= av;
            for (int s = 0; s < N; s++) begin
                rem[s+1] <= r_n[s];
                qd[s+1]  <= q_n[s];
                dvs[s+1] <= dvs[s];
            end
            valid_o   <= v[N];
            quotient  <= dbz[N] ? '1 : ovf[N] ? smin : sq[N] ? -qd[N] : qd[N];
            // with a zero divisor rem holds |dividend|, so the sign fix-up restores the original
            remainder <= ovf[N] ? '0 : sr[N] ? -rem[N] : rem[N];
            dbz_o     <= v[N] & dbz[N];
        end
    end
endmodule

// File: tb/tb_div_pipe_sgn.sv
// tb_div_pipe_sgn: scoreboard bench for div_pipe_sgn with directed and random steps
module tb_div_pipe_sgn;
    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } res_t;

    logic clk = 0, rst_n = 0, en = 1, valid_i = 0, signed_i = 0;
    logic [31:0] dividend = 0, divisor = 1;
    logic valid_o, dbz_o;
    logic [31:0] quotient, remainder;
    int vec = 0, bad = 0;
    res_t sb[$];

    div_pipe_sgn dut (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_i(valid_i), .signed_i(signed_i),
        .dividend(dividend), .divisor(divisor), .valid_o(valid_o),
        .quotient(quotient), .remainder(remainder), .dbz_o(dbz_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        res_t x;
        x.z = 0;
        if (b == 0) begin
            x.q = 32'hFFFF_FFFF;
            x.r = a;
            x.z = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            x.q = 32'h8000_0000;
            x.r = 0;
        end else if (s) begin
            x.q = $signed(a) / $signed(b);
            x.r = $signed(a) % $signed(b);
        end else begin
            x.q = a / b;
            x.r = a % b;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        logic e;
        res_t x;
        e = en;
        if (rst_n && en && valid_i) sb.push_back(model(dividend, divisor, signed_i));
        #1;
        if (rst_n && e && valid_o) begin
            if (sb.size() == 0) chk("unexpected_valid", 32'(valid_o), 0);
            else begin
                x = sb.pop_front();
                chk("quotient", quotient, x.q);
                chk("remainder", remainder, x.r);
                chk("dbz", 32'(dbz_o), 32'(x.z));
            end
        end
    end

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        en = 1; valid_i = 1; signed_i = s; dividend = a; divisor = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en = 1; valid_i = 0;
        end
    endtask

    task automatic lat_check(input string tag);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            valid_i = 0;
            chk(tag, 32'(valid_o), 32'(i == 6));
        end
    endtask

    initial begin
        #12;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", 32'(dbz_o), 0);
        @(negedge clk);
        rst_n = 1;
        idle(2);

        op(100, 7, 0);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            valid_i = 0;
            chk("lat_first", 32'(valid_o), 32'(i == 6));
            if (i == 6) begin
                chk("q_100_7", quotient, 14);
                chk("r_100_7", remainder, 2);
            end
        end

        op(-7, 2, 1);
        op(7, -2, 1);
        op(32'hFFFF_FFF9, 2, 0);
        op(32'h1234_5678, 0, 0);
        op(-5, 0, 1);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1);
        op(32'h8000_0000, 32'hFFFF_FFFF, 0);
        idle(8);

        op(1000, 9, 0);
        idle(5);
        @(negedge clk);
        en = 0;
        repeat (4) begin
            @(negedge clk);
            chk("frozen_valid", 32'(valid_o), 1);
            chk("frozen_q", quotient, 111);
            chk("frozen_r", remainder, 1);
        end
        en = 1;
        idle(2);

        op(50, 3, 0);
        op(-50, 3, 1);
        @(negedge clk);
        en = 0; valid_i = 1; dividend = 77; divisor = 5; signed_i = 0;
        repeat (3) @(negedge clk);
        dividend = 99;
        @(negedge clk);
        en = 1;
        idle(12);

        op(11, 2, 0);
        op(22, 3, 0);
        op(33, 4, 0);
        op(44, 5, 0);
        idle(1);
        @(posedge clk);
        #2 rst_n = 0;
        sb.delete();
        #1;
        chk("arst_valid", 32'(valid_o), 0);
        chk("arst_q", quotient, 0);
        chk("arst_r", remainder, 0);
        chk("arst_dbz", 32'(dbz_o), 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            valid_i = 0;
            chk("post_rst_quiet", 32'(valid_o), 0);
        end
        op(200, 6, 1);
        lat_check("lat_after_rst");

        for (int i = 0; i < 10000; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = $urandom_range(1, 300) * (($urandom_range(0, 1) != 0) ? 1 : -1);
                4: a = $urandom_range(0, 1000);
                default: ;
            endcase
            @(negedge clk);
            en = $urandom_range(0, 3) != 0;
            valid_i = $urandom_range(0, 3) != 0;
            signed_i = $urandom_range(0, 1);
            dividend = a;
            divisor = b;
        end
        idle(20);
        chk("drain_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
